// File: rtl/mbl_msg_arb.sv
// Round-robin arbiter for the mbl request port: holds a grant for a whole message, tags beats with the
// requester index and routes responses back by tag. Build macro MBL_ARB_TIMEOUT_EN adds a stall watchdog.
module mbl_msg_arb #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 32,
   parameter int ID_W        = 3,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        s_valid,
   output logic [NUM_REQ-1:0]        s_ready,
   input  logic [NUM_REQ*DATA_W-1:0] s_data,
   input  logic [NUM_REQ-1:0]        s_last,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [DATA_W-1:0]         m_data,
   output logic                      m_last,
   output logic [ID_W-1:0]           m_id,
   input  logic                      r_valid,
   output logic                      r_ready,
   input  logic [DATA_W-1:0]         r_data,
   input  logic [ID_W-1:0]           r_id,
   output logic [NUM_REQ-1:0]        s_r_valid,
   input  logic [NUM_REQ-1:0]        s_r_ready,
   output logic [DATA_W-1:0]         s_r_data,
   output logic                      resp_err,
   output logic                      timeout_err
);

   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [GW-1:0] LAST_IDX = GW'(NUM_REQ - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [GW-1:0]     grant_r;
   logic [GW-1:0]     grant_nxt_s;
   logic [GW-1:0]     rr_ptr_r;
   logic [GW-1:0]     rr_ptr_nxt_s;
   logic [GW-1:0]     grant_inc_s;
   logic [GW:0]       idle_srch_s;
   logic [GW:0]       rearb_srch_s;
   logic              sel_valid_s;
   logic              sel_last_s;
   logic [DATA_W-1:0] sel_data_s;
   logic              beat_acc_s;
   logic              last_acc_s;
   logic              to_hit_s;
   logic              rid_ok_s;
   logic              resp_err_r;
   logic              timeout_err_r;

   // Returns {hit, index}: first set bit of req among span entries starting at start, wrapping.
   function automatic logic [GW:0] rr_search(input logic [NUM_REQ-1:0] req,
                                             input logic [GW-1:0]      start,
                                             input int                 span);
      logic [GW:0] res;
      int          idx;
      res = {(GW+1){1'b0}};
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(start) + k) % NUM_REQ;
         if ((k < span) && req[idx]) begin
            res = {1'b1, GW'(idx)};
         end
      end
      return res;
   endfunction

   assign grant_inc_s  = (grant_r == LAST_IDX) ? {GW{1'b0}} : (grant_r + GW'(1));
   assign idle_srch_s  = rr_search(s_valid, rr_ptr_r, NUM_REQ);
   // Re-arbitration skips the current owner by searching only the other NUM_REQ-1 slots.
   assign rearb_srch_s = rr_search(s_valid, grant_inc_s, NUM_REQ - 1);

   assign sel_valid_s = s_valid[grant_r];
   assign sel_last_s  = s_last[grant_r];
   assign sel_data_s  = s_data[int'(grant_r)*DATA_W +: DATA_W];
   assign beat_acc_s  = (state_r == BUSY) && sel_valid_s && m_ready;
   assign last_acc_s  = beat_acc_s && sel_last_s;

   // Next-state, grant and round-robin pointer selection
   always_comb begin
      state_nxt_s  = state_r;
      grant_nxt_s  = grant_r;
      rr_ptr_nxt_s = rr_ptr_r;
      case (state_r)
         IDLE: begin
            if (idle_srch_s[GW]) begin
               state_nxt_s = BUSY;
               grant_nxt_s = idle_srch_s[GW-1:0];
            end else begin
               state_nxt_s = IDLE;
            end
         end
         BUSY: begin
            if (last_acc_s) begin
               rr_ptr_nxt_s = grant_inc_s;
               if (rearb_srch_s[GW]) begin
                  state_nxt_s = BUSY;
                  grant_nxt_s = rearb_srch_s[GW-1:0];
               end else begin
                  state_nxt_s = IDLE;
               end
            end else if (to_hit_s) begin
               rr_ptr_nxt_s = grant_inc_s;
               state_nxt_s  = IDLE;
            end else begin
               state_nxt_s = BUSY;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Arbiter state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= IDLE;
         grant_r  <= {GW{1'b0}};
         rr_ptr_r <= {GW{1'b0}};
      end else begin
         state_r  <= state_nxt_s;
         grant_r  <= grant_nxt_s;
         rr_ptr_r <= rr_ptr_nxt_s;
      end
   end

   // Outbound mux: only the granted requester sees the downstream ready
   always_comb begin
      m_valid = 1'b0;
      m_data  = {DATA_W{1'b0}};
      m_last  = 1'b0;
      m_id    = {ID_W{1'b0}};
      s_ready = {NUM_REQ{1'b0}};
      if (state_r == BUSY) begin
         m_valid          = sel_valid_s;
         m_data           = sel_data_s;
         m_last           = sel_last_s;
         m_id             = ID_W'(grant_r);
         s_ready[grant_r] = m_ready;
      end else begin
         m_valid = 1'b0;
      end
   end

   // Response demux by tag; out-of-range tags are swallowed
   always_comb begin
      rid_ok_s  = (int'(r_id) < NUM_REQ);
      s_r_valid = {NUM_REQ{1'b0}};
      r_ready   = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rid_ok_s && (int'(r_id) == i)) begin
            s_r_valid[i] = r_valid;
            r_ready      = s_r_ready[i];
         end else begin
            s_r_valid[i] = 1'b0;
         end
      end
   end

   assign s_r_data = r_data;

`ifdef MBL_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] stall_cnt_nxt_s;

   // Watchdog: counts granted cycles without a valid beat, cleared by any accepted beat
   always_comb begin
      stall_cnt_nxt_s = stall_cnt_r;
      to_hit_s        = 1'b0;
      if (state_r != BUSY) begin
         stall_cnt_nxt_s = {CNT_W{1'b0}};
      end else if (!sel_valid_s) begin
         if (stall_cnt_r == CNT_W'(TIMEOUT_CYC - 1)) begin
            to_hit_s        = 1'b1;
            stall_cnt_nxt_s = {CNT_W{1'b0}};
         end else begin
            stall_cnt_nxt_s = stall_cnt_r + CNT_W'(1);
         end
      end else if (m_ready) begin
         stall_cnt_nxt_s = {CNT_W{1'b0}};
      end else begin
         stall_cnt_nxt_s = stall_cnt_r;
      end
   end

   // Watchdog counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else begin
         stall_cnt_r <= stall_cnt_nxt_s;
      end
   end
`else
   // Watchdog absent: the expression is constant 0 and only keeps the parameter referenced.
   assign to_hit_s = 1'b0 & (TIMEOUT_CYC == 0);
`endif

   // Registered error pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         resp_err_r    <= 1'b0;
         timeout_err_r <= 1'b0;
      end else begin
         resp_err_r    <= r_valid && !rid_ok_s;
         timeout_err_r <= to_hit_s;
      end
   end

   assign resp_err    = resp_err_r;
   assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_mbl_msg_arb.sv
// Self-checking bench for mbl_msg_arb: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a message-level behavioural model.
module tb_mbl_msg_arb;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int IW = 3;
   localparam int T  = 16;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    s_valid;
   logic [N-1:0]    s_ready;
   logic [N*DW-1:0] s_data;
   logic [N-1:0]    s_last;
   logic            m_valid;
   logic            m_ready;
   logic [DW-1:0]   m_data;
   logic            m_last;
   logic [IW-1:0]   m_id;
   logic            r_valid;
   logic            r_ready;
   logic [DW-1:0]   r_data;
   logic [IW-1:0]   r_id;
   logic [N-1:0]    s_r_valid;
   logic [N-1:0]    s_r_ready;
   logic [DW-1:0]   s_r_data;
   logic            resp_err;
   logic            timeout_err;

   always #5 clk = ~clk;

   mbl_msg_arb #(.NUM_REQ(N), .DATA_W(DW), .ID_W(IW), .TIMEOUT_CYC(T)) dut (
      .clk(clk), .reset(reset),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_id(m_id),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_id(r_id),
      .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data),
      .resp_err(resp_err), .timeout_err(timeout_err)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Model: owner is the granted requester (-1 when nobody holds the port), ptr where the next search starts.
   int           owner = -1;
   int           ptr   = 0;
   int           stall = 0;
   logic         exp_rerr = 1'b0;
   logic         exp_terr = 1'b0;
   logic [N-1:0] exp_s_ready = '0;
   logic [N-1:0] acc = '0;

   logic [N-1:0]  vld;
   logic [DW-1:0] dat [N];
   logic [N-1:0]  lst;
   int            rem [N];

   task automatic ck(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input int start, input int cnt);
      for (int k = 0; k < cnt; k++) begin
         if (s_valid[(start + k) % N]) return (start + k) % N;
      end
      return -1;
   endfunction

   task automatic set_req(input int i, input logic v, input logic [DW-1:0] d, input logic l);
      s_valid[i]          = v;
      s_data[i*DW +: DW]  = d;
      s_last[i]           = l;
   endtask

   task automatic chk();
      logic         exp_mv;
      logic         exp_rr;
      logic [N-1:0] exp_srv;
      @(negedge clk);
      exp_mv      = 1'b0;
      exp_s_ready = '0;
      if (owner >= 0) begin
         exp_mv             = s_valid[owner];
         exp_s_ready[owner] = m_ready;
         ck("m_data", 64'(m_data), 64'(s_data[owner*DW +: DW]));
         ck("m_last", 64'(m_last), 64'(s_last[owner]));
         ck("m_id",   64'(m_id),   64'(owner));
      end
      ck("m_valid", 64'(m_valid), 64'(exp_mv));
      ck("s_ready", 64'(s_ready), 64'(exp_s_ready));
      exp_srv = '0;
      exp_rr  = 1'b1;
      if (int'(r_id) < N) begin
         exp_rr = s_r_ready[r_id];
         if (r_valid) exp_srv[r_id] = 1'b1;
      end
      ck("s_r_valid",   64'(s_r_valid),   64'(exp_srv));
      ck("r_ready",     64'(r_ready),     64'(exp_rr));
      ck("s_r_data",    64'(s_r_data),    64'(r_data));
      ck("resp_err",    64'(resp_err),    64'(exp_rerr));
      ck("timeout_err", 64'(timeout_err), 64'(exp_terr));
   endtask

   task automatic adv();
      @(posedge clk);
      acc = exp_s_ready & s_valid;
      if (reset) begin
         owner = -1; ptr = 0; stall = 0; exp_rerr = 1'b0; exp_terr = 1'b0;
      end else begin
         exp_rerr = r_valid && (int'(r_id) >= N);
         exp_terr = 1'b0;
         if (owner < 0) begin
            owner = pick(ptr, N);
         end else if (s_valid[owner] && m_ready && s_last[owner]) begin
            ptr   = (owner + 1) % N;
            owner = pick(ptr, N - 1);
            stall = 0;
         end
`ifdef MBL_ARB_TIMEOUT_EN
         else if (!s_valid[owner]) begin
            stall++;
            if (stall == T) begin
               ptr = (owner + 1) % N; owner = -1; stall = 0; exp_terr = 1'b1;
            end
         end else if (m_ready) begin
            stall = 0;
         end
`endif
      end
      #1;
   endtask

   task automatic cyc();
      chk();
      adv();
   endtask

   task automatic do_reset();
      reset = 1'b1; s_valid = '0; s_last = '0; m_ready = 1'b0;
      r_valid = 1'b0; s_r_ready = '0; r_id = '0;
      cyc(); cyc();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; s_valid = '0; s_data = '0; s_last = '0; m_ready = 1'b0;
      r_valid = 1'b0; r_data = '0; r_id = '0; s_r_ready = '0;
      adv(); adv();
      chk();
      ck("rst_m_valid", 64'(m_valid), 64'(0));
      ck("rst_s_ready", 64'(s_ready), 64'(0));
      ck("rst_resp_err", 64'(resp_err), 64'(0));
      adv();
      reset = 1'b0;

      // Single beat, then the same requester again: one idle cycle in between
      m_ready = 1'b1; set_req(0, 1'b1, 32'hA5, 1'b1);
      chk(); ck("sb_t_m_valid", 64'(m_valid), 64'(0)); adv();
      chk();
      ck("sb_m_valid", 64'(m_valid), 64'(1)); ck("sb_m_data", 64'(m_data), 64'hA5);
      ck("sb_m_id", 64'(m_id), 64'(0)); ck("sb_m_last", 64'(m_last), 64'(1));
      ck("sb_s_ready", 64'(s_ready), 64'h1);
      adv();
      set_req(0, 1'b1, 32'h5A, 1'b1);
      chk(); ck("sb_idle_m_valid", 64'(m_valid), 64'(0)); ck("sb_idle_s_ready", 64'(s_ready), 64'(0)); adv();
      chk(); ck("sb2_m_data", 64'(m_data), 64'h5A); adv();
      set_req(0, 1'b0, 32'h0, 1'b0);
      cyc();

      // Fairness
      do_reset();
      m_ready = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'h100 + 32'(i), 1'b1);
      chk(); ck("fair_first_idle", 64'(m_valid), 64'(0)); adv();
      for (int k = 0; k < 12; k++) begin
         chk(); ck("fair_m_id", 64'(m_id), 64'(k % 4)); ck("fair_m_valid", 64'(m_valid), 64'(1)); adv();
      end
      s_valid = '0;

      // Message lock with a downstream stall
      do_reset();
      m_ready = 1'b1; set_req(1, 1'b1, 32'h11, 1'b0);
      cyc();
      chk(); ck("lock_b1_id", 64'(m_id), 64'(1)); ck("lock_b1_data", 64'(m_data), 64'h11); adv();
      set_req(1, 1'b1, 32'h12, 1'b0); set_req(2, 1'b1, 32'h21, 1'b1); m_ready = 1'b0;
      chk(); ck("lock_stall_data", 64'(m_data), 64'h12); ck("lock_stall_id", 64'(m_id), 64'(1)); adv();
      m_ready = 1'b1;
      chk(); ck("lock_b2_data", 64'(m_data), 64'h12); ck("lock_b2_id", 64'(m_id), 64'(1)); adv();
      set_req(1, 1'b1, 32'h13, 1'b1);
      chk(); ck("lock_b3_id", 64'(m_id), 64'(1)); ck("lock_b3_last", 64'(m_last), 64'(1)); adv();
      set_req(1, 1'b0, 32'h0, 1'b0);
      chk(); ck("lock_next_id", 64'(m_id), 64'(2)); ck("lock_next_valid", 64'(m_valid), 64'(1));
      ck("lock_next_data", 64'(m_data), 64'h21); adv();
      set_req(2, 1'b0, 32'h0, 1'b0);
      cyc();

      // Response routing
      r_valid = 1'b1; r_id = 3'd2; s_r_ready = 4'b0000; r_data = 32'hDEADBEEF;
      chk(); ck("rsp_srv", 64'(s_r_valid), 64'h4); ck("rsp_rready0", 64'(r_ready), 64'(0)); adv();
      s_r_ready = 4'b0100;
      chk(); ck("rsp_rready1", 64'(r_ready), 64'(1)); ck("rsp_srv2", 64'(s_r_valid), 64'h4); adv();
      r_id = 3'd5;
      chk(); ck("rsp_bad_rready", 64'(r_ready), 64'(1)); ck("rsp_bad_srv", 64'(s_r_valid), 64'(0)); adv();
      r_valid = 1'b0;
      chk(); ck("rsp_err_pulse", 64'(resp_err), 64'(1)); adv();
      chk(); ck("rsp_err_clear", 64'(resp_err), 64'(0)); adv();

      // Reset in the middle of a message
      do_reset();
      m_ready = 1'b1; set_req(1, 1'b1, 32'h31, 1'b1);
      cyc(); cyc();
      set_req(1, 1'b0, 32'h0, 1'b0); set_req(3, 1'b1, 32'h41, 1'b0);
      cyc(); cyc();
      set_req(3, 1'b1, 32'h42, 1'b0); reset = 1'b1;
      chk(); ck("rmid_id", 64'(m_id), 64'(3)); ck("rmid_valid", 64'(m_valid), 64'(1)); adv();
      reset = 1'b0; set_req(3, 1'b1, 32'h41, 1'b0); set_req(0, 1'b1, 32'h01, 1'b1);
      chk(); ck("rmid_after_valid", 64'(m_valid), 64'(0)); ck("rmid_after_ready", 64'(s_ready), 64'(0)); adv();
      chk(); ck("rmid_regrant", 64'(m_id), 64'(0)); adv();
      set_req(0, 1'b0, 32'h0, 1'b0);
      cyc();

`ifdef MBL_ARB_TIMEOUT_EN
      // Watchdog drops a grant whose owner went silent
      do_reset();
      m_ready = 1'b1; set_req(3, 1'b1, 32'h51, 1'b0);
      cyc(); cyc();
      set_req(3, 1'b0, 32'h0, 1'b0); set_req(0, 1'b1, 32'h61, 1'b1);
      for (int k = 0; k < T; k++) begin
         chk(); ck("to_quiet", 64'(timeout_err), 64'(0)); adv();
      end
      chk(); ck("to_pulse", 64'(timeout_err), 64'(1)); ck("to_idle", 64'(m_valid), 64'(0)); adv();
      chk(); ck("to_regrant", 64'(m_id), 64'(0)); ck("to_regrant_valid", 64'(m_valid), 64'(1)); adv();
      set_req(0, 1'b0, 32'h0, 1'b0);
`endif

      // Randomized traffic
      do_reset();
      vld = '0; lst = '0;
      for (int i = 0; i < N; i++) begin
         rem[i] = 0; dat[i] = '0;
      end
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
               vld[i] = 1'b0;
               if (rem[i] > 0) rem[i]--;
            end
            if (!vld[i]) begin
               if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = int'($urandom_range(1, 4));
               if (rem[i] > 0 && $urandom_range(0, 4) != 0) begin
                  vld[i] = 1'b1; dat[i] = $urandom; lst[i] = (rem[i] == 1);
               end
            end
            set_req(i, vld[i], dat[i], lst[i]);
         end
         m_ready   = ($urandom_range(0, 3) != 0);
         r_valid   = 1'($urandom_range(0, 1));
         r_id      = 3'($urandom_range(0, 7));
         r_data    = $urandom;
         s_r_ready = 4'($urandom);
         reset     = ($urandom_range(0, 499) == 0);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mbl_msg_arb.md
Name: mbl_msg_arb

Overview:
- Round-robin arbiter sharing one message-bus (mbl) request master port among NUM_REQ internal requesters.
- Holds a grant for a whole multi-beat message, until the last beat is accepted.
- Tags each outbound beat with the requester index.
- Demultiplexes returning responses to the originating requester by tag.
- Sits between child blocks issuing msg requests and the top-level request/response interfaces.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, message beat width.
- ID_W, 3, tag width; must be ≥ clog2(NUM_REQ).
- TIMEOUT_CYC, 16, stall limit used only when MBL_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  NUM_REQ  per-requester beat valid.
- s_ready  out  NUM_REQ  per-requester beat accept.
- s_data  in  NUM_REQ*DATA_W  per-requester beat data; requester i occupies bits [i*DATA_W +: DATA_W].
- s_last  in  NUM_REQ  per-requester last beat of message.
- m_valid  out  1  outbound beat valid.
- m_ready  in  1  outbound beat accept.
- m_data  out  DATA_W  outbound beat data.
- m_last  out  1  outbound last beat.
- m_id  out  ID_W  index of the granted requester.
- r_valid  in  1  response valid.
- r_ready  out  1  response accept.
- r_data  in  DATA_W  response data.
- r_id  in  ID_W  response tag.
- s_r_valid  out  NUM_REQ  per-requester response valid.
- s_r_ready  in  NUM_REQ  per-requester response accept.
- s_r_data  out  DATA_W  response data, broadcast to all requesters.
- resp_err  out  1  one-cycle pulse: response carried an out-of-range tag.
- timeout_err  out  1  one-cycle pulse: grant dropped by the watchdog.

Behaviour:
- Reset state:
  - state=IDLE, rr_ptr=0, grant=0.
  - Registered outputs resp_err=0, timeout_err=0.
  - Combinational outputs m_valid=0 and s_ready=0 while in IDLE.
- Handshake: a beat transfers when valid && ready.
  - A requester holds valid, data and last stable until accepted.
  - The outbound side is the same: m_* stays stable while m_valid && !m_ready.
- State IDLE:
  - Search s_valid starting at rr_ptr, wrapping modulo NUM_REQ.
  - First hit i: register grant=i, go to BUSY.
  - No beat passes in IDLE, so arbitration latency is 1 cycle.
- State BUSY:
  - m_valid=s_valid[grant], m_data/m_last=s_data/s_last of grant, m_id=grant (zero-extended).
  - s_ready[grant]=m_ready; all other s_ready=0.
- Last beat accepted in BUSY (m_valid && m_ready && m_last):
  - rr_ptr=grant+1 (wraps).
  - Same-cycle re-arbitration over s_valid, excluding the current grant, searching from grant+1.
  - Hit: new grant, stay in BUSY, no bubble.
  - No hit: go to IDLE.
  - A requester that is alone and issuing back-to-back messages sees one idle cycle between messages.
- Non-last beats never release the grant. Other requesters' valids are ignored during a message.
- Response path (combinational, no state):
  - r_id < NUM_REQ: s_r_valid[r_id]=r_valid, all other bits 0; r_ready=s_r_ready[r_id].
  - r_id ≥ NUM_REQ: all s_r_valid=0, r_ready=1 (response dropped); resp_err pulses 1 in the next cycle for each dropped beat.
  - s_r_data=r_data always.
- Reset asserted mid-message:
  - Next edge forces IDLE and rr_ptr=0.
  - The partial message is abandoned; the requester must restart it.
- Simultaneous events: response demux is independent of request arbitration; both may transfer in the same cycle.

Optional Feature:
- Macro MBL_ARB_TIMEOUT_EN.
- Defined:
  - An internal counter counts BUSY cycles with s_valid[grant]=0; it clears on any accepted beat and on grant change.
  - When the count reaches TIMEOUT_CYC: go to IDLE, rr_ptr=grant+1, timeout_err=1 for one cycle.
  - No fabricated last beat is sent downstream.
- Not defined:
  - No counter logic.
  - timeout_err tied 0.
  - A grant may be held indefinitely.

Test Plan:
- Single beat:
  - Stimulus: after reset, s_valid[0]=1, s_data[0]=0xA5, s_last[0]=1 at cycle t; m_ready=1.
  - Required: m_valid=1, m_data=0xA5, m_id=0, m_last=1 at t+1; s_ready[0]=1 at t+1; IDLE at t+2.
- Fairness:
  - Stimulus: all 4 requesters continuously offer 1-beat messages; m_ready=1.
  - Required: m_id sequence 0,1,2,3,0,1,...; one message per cycle after the first grant.
- Message lock:
  - Stimulus: req1 sends a 3-beat message; req2 asserts valid at beat 2; m_ready toggles 1,0,1,1.
  - Required: m_data stable during the stall; req2 not granted until req1's last beat is accepted, then m_id=2 with no bubble.
- Response routing:
  - Stimulus: r_valid=1, r_id=2, s_r_ready[2]=0 → required: s_r_valid=4'b0100, r_ready=0.
  - Stimulus: raise s_r_ready[2] → required: r_ready=1.
  - Stimulus: r_id=5 → required: r_ready=1, s_r_valid=0, resp_err=1 in the next cycle.
- Reset mid-message:
  - Stimulus: assert reset during beat 2 of a 4-beat message.
  - Required: m_valid=0, s_ready=0 after the edge; the next grant after reset searches from index 0.
- Timeout (MBL_ARB_TIMEOUT_EN, TIMEOUT_CYC=16):
  - Stimulus: req3 sends beat 1 (non-last), then drops valid; req0 is waiting.
  - Required: timeout_err=1 after 16 idle cycles; the subsequent grant goes to req0.
